// File: rtl/regfile_sb_if.sv
// Register-file bus: writeback, issue and the two read ports with their scoreboard bits.
interface regfile_sb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
);
  localparam int unsigned AW = $clog2(NREG);

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            iss_en;
  logic [AW-1:0]   iss_addr;
  logic [AW-1:0]   rd_addr_a;
  logic [AW-1:0]   rd_addr_b;
  logic [XLEN-1:0] rd_data_a;
  logic [XLEN-1:0] rd_data_b;
  logic            busy_a;
  logic            busy_b;
  logic            init_done;

  modport master (
    output wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, busy_a, busy_b, init_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, iss_en, iss_addr, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, busy_a, busy_b, init_done
  );
endinterface

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with a busy scoreboard and a post-reset clear sweep.
module regfile_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int unsigned AW   = $clog2(NREG);
  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state;
  logic [AW-1:0]   cnt;
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic            wr_ok;
  logic            iss_ok;
  logic [XLEN-1:0] rd_a_nxt;
  logic [XLEN-1:0] rd_b_nxt;
  logic [XLEN-1:0] rd_data_a;
  logic [XLEN-1:0] rd_data_b;
  logic            busy_a;
  logic            busy_b;
  logic            init_done;

  // Scoreboard update and write-through read data; register 0 is excluded everywhere.
  always_comb begin
    wr_ok    = bus.wr_en  && (bus.wr_addr  != '0);
    iss_ok   = bus.iss_en && (bus.iss_addr != '0);
    busy_nxt = busy;
    if (wr_ok)  busy_nxt[bus.wr_addr]  = 1'b0;
    if (iss_ok) busy_nxt[bus.iss_addr] = 1'b1;   // issue wins over same-cycle writeback

    rd_a_nxt = regs[bus.rd_addr_a];
    if (wr_ok && (bus.wr_addr == bus.rd_addr_a)) rd_a_nxt = bus.wr_data;
    if (bus.rd_addr_a == '0) rd_a_nxt = '0;

    rd_b_nxt = regs[bus.rd_addr_b];
    if (wr_ok && (bus.wr_addr == bus.rd_addr_b)) rd_b_nxt = bus.wr_data;
    if (bus.rd_addr_b == '0) rd_b_nxt = '0;
  end

  // Sweep/run FSM, storage and registered read outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      cnt       <= '0;
      busy      <= '0;
      rd_data_a <= '0;
      rd_data_b <= '0;
      busy_a    <= 1'b0;
      busy_b    <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          regs[cnt] <= '0;
          rd_data_a <= '0;
          rd_data_b <= '0;
          busy_a    <= 1'b0;
          busy_b    <= 1'b0;
          if (cnt == LAST) begin
            state     <= RUN;
            init_done <= 1'b1;
          end else begin
            cnt       <= cnt + AW'(1);
            init_done <= 1'b0;
          end
        end
        RUN: begin
          if (wr_ok) regs[bus.wr_addr] <= bus.wr_data;
          busy      <= busy_nxt;
          rd_data_a <= rd_a_nxt;
          rd_data_b <= rd_b_nxt;
          busy_a    <= busy_nxt[bus.rd_addr_a];
          busy_b    <= busy_nxt[bus.rd_addr_b];
          init_done <= 1'b1;
        end
      endcase
    end
  end

  assign bus.rd_data_a = rd_data_a;
  assign bus.rd_data_b = rd_data_b;
  assign bus.busy_a    = busy_a;
  assign bus.busy_b    = busy_b;
  assign bus.init_done = init_done;
endmodule
